// File: rtl/aes_selftest_sequencer.sv
// -----------------------------------------------------------------------------
// aes_selftest_sequencer
//
// Purpose:
//   Runs the AES known-answer self-test. It steps the cipher and decipher
//   datapaths (AES-128/192/256) through the FIPS-197 Appendix C vectors. For
//   each test it pulses core_start, waits LATENCY cycles, and compares the
//   selected datapath result with an internal expected-value ROM. It reports
//   per-test pass bits and an overall isEqual. It also keeps the low result
//   byte for the 7-segment BCD path.
//
// Configuration macro:
//   AES_SELFTEST_HOLD_EN
//     Defined   : a HOLD state keeps each test's disp_byte visible for
//                 HOLD_CYCLES cycles before the next test starts.
//     Undefined : CHECK goes straight to the next START or to DONE, and
//                 HOLD_CYCLES is not used.
//
// Parameters:
//   LATENCY      cycles from core_start to a stable result (1..255)
//   HOLD_CYCLES  display dwell per test, used only with the hold macro (>=1)
//
// Ports:
//   clk         in   single clock
//   reset       in   synchronous, active-high
//   enable      in   a rising edge starts a run; a low level aborts a run or
//                    re-arms the block after DONE
//   mode[1:0]   in   00 AES-128, 01 AES-192, 10 AES-256, 11 all six tests;
//                    sampled only when a run starts
//   result[127:0] in output of the datapath selected by sel_test
//   sel_test[2:0] out test index {key[1:0], dec}
//   core_start  out  one-cycle start pulse per test
//   busy        out  high from START through the last CHECK/HOLD
//   done        out  high in DONE
//   isEqual     out  AND of the pass bits of the tests in this run; valid
//                    while done is high
//   pass_mask[5:0] out bit i set when test i matched
//   disp_byte[7:0] out result[7:0] captured in CHECK
//   dbg_state[2:0] out current FSM state encoding
//
// Start/result contract with the datapath:
//   core_start is high for exactly one cycle (START), and sel_test does not
//   change until that test's CHECK (or HOLD) ends. The datapath must present
//   a stable result LATENCY cycles after core_start. There is no
//   back-pressure: the sequencer samples result at the clock edge that ends
//   the CHECK cycle.
// -----------------------------------------------------------------------------
module aes_selftest_sequencer #(
  parameter int LATENCY     = 12,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   mode,
  input  logic [127:0] result,
  output logic [2:0]   sel_test,
  output logic         core_start,
  output logic         busy,
  output logic         done,
  output logic         isEqual,
  output logic [5:0]   pass_mask,
  output logic [7:0]   disp_byte,
  output logic [2:0]   dbg_state
);

  // Reject illegal parameter values when the design is elaborated.
  if (LATENCY < 1 || LATENCY > 255 || HOLD_CYCLES < 1) begin : g_param_check
    $error("aes_selftest_sequencer: LATENCY must be 1..255 and HOLD_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
`ifdef AES_SELFTEST_HOLD_EN
    S_HOLD  = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  // The wait counter is loaded in START. WAIT lasts LATENCY-1 cycles, so
  // CHECK falls exactly LATENCY cycles after core_start.
  localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

`ifdef AES_SELFTEST_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
`endif

  // Expected results: FIPS-197 Appendix C. Even indices are cipher outputs.
  // Odd indices are decipher outputs, which are always the plaintext.
  function automatic logic [127:0] rom_value(input logic [2:0] idx);
    logic [127:0] v;
    v = 128'h0;
    case (idx)
      3'd0:                v = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      3'd2:                v = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      3'd4:                v = 128'h8ea2b7ca516745bfeafc49904b496089;
      3'd1, 3'd3, 3'd5:    v = 128'h00112233445566778899aabbccddeeff;
      default:             v = 128'h0;
    endcase
    return v;
  endfunction

  // Mode 11 runs every test from 0. Other modes run the key-size pair {2m, 2m+1}.
  function automatic logic [2:0] first_idx(input logic [1:0] m);
    return (m == 2'b11) ? 3'd0 : {m, 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        enable_q;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  wait_q, wait_d;
  logic [5:0]  pass_q, pass_d;
  logic [7:0]  disp_q, disp_d;
  logic        iseq_q, iseq_d;
`ifdef AES_SELFTEST_HOLD_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  logic [2:0]  last_idx;
  logic [5:0]  run_mask;
  logic [5:0]  sel_bit;
  logic        hit;
  logic        rise;

  assign last_idx = (mode_q == 2'b11) ? 3'd5 : {mode_q, 1'b1};
  assign run_mask = (mode_q == 2'b11) ? 6'b111111
                                      : (6'b000011 << {mode_q, 1'b0});
  assign sel_bit  = 6'(6'b000001 << sel_q);
  assign hit      = (result == rom_value(sel_q));
  assign rise     = enable & ~enable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      // Treat enable as already high after reset. A level that is held
      // through reset then cannot look like a new rising edge.
      enable_q <= 1'b1;
      mode_q   <= 2'b00;
      sel_q    <= 3'd0;
      wait_q   <= 8'd0;
      pass_q   <= 6'd0;
      disp_q   <= 8'd0;
      iseq_q   <= 1'b0;
`ifdef AES_SELFTEST_HOLD_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      wait_q   <= wait_d;
      pass_q   <= pass_d;
      disp_q   <= disp_d;
      iseq_q   <= iseq_d;
`ifdef AES_SELFTEST_HOLD_EN
      hold_q   <= hold_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and register-update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    pass_d  = pass_q;
    disp_d  = disp_q;
    iseq_d  = iseq_q;
`ifdef AES_SELFTEST_HOLD_EN
    hold_d  = hold_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_START;
          mode_d  = mode;
          pass_d  = 6'd0;
          sel_d   = first_idx(mode);
        end
      end

      S_START: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          wait_d  = WAIT_LOAD;
          // LATENCY of 1 leaves no cycle for WAIT, so go directly to CHECK.
          state_d = (LATENCY == 1) ? S_CHECK : S_WAIT;
        end
      end

      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - 8'd1;
          if (wait_q <= 8'd1) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (!enable) begin
          // An abort leaves the partial pass mask untouched.
          state_d = S_IDLE;
        end else begin
          pass_d = (pass_q & ~sel_bit) | (hit ? sel_bit : 6'd0);
          disp_d = result[7:0];
`ifdef AES_SELFTEST_HOLD_EN
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
`else
          if (sel_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            sel_d   = sel_q + 3'd1;
          end
`endif
        end
      end

`ifdef AES_SELFTEST_HOLD_EN
      S_HOLD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (hold_q == '0) begin
          if (sel_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            sel_d   = sel_q + 3'd1;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
`endif

      S_DONE: begin
        // A level held high does not restart the run. Only a drop re-arms it.
        if (!enable) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // isEqual is computed once, on entry to DONE. The computation uses the
    // pass mask that includes the final test. isEqual reads zero outside DONE.
    if (state_d == S_DONE) begin
      if (state_q != S_DONE) begin
        iseq_d = &(pass_d | ~run_mask);
      end
    end else begin
      iseq_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sel_test   = sel_q;
  assign core_start = (state_q == S_START);
  assign done       = (state_q == S_DONE);
  assign isEqual    = iseq_q;
  assign pass_mask  = pass_q;
  assign disp_byte  = disp_q;
  assign dbg_state  = state_q;

`ifdef AES_SELFTEST_HOLD_EN
  assign busy = (state_q == S_START) || (state_q == S_WAIT) ||
                (state_q == S_CHECK) || (state_q == S_HOLD);
`else
  assign busy = (state_q == S_START) || (state_q == S_WAIT) ||
                (state_q == S_CHECK);
`endif

endmodule

// File: doc/aes_selftest_sequencer.md
# aes_selftest_sequencer

Sequencer for the AES known-answer self-test. It steps the cipher/decipher datapaths (AES-128/192/256) through the FIPS-197 Appendix C vectors and starts each operation. It waits a fixed latency, then compares the result against an internal expected-value ROM. It reports per-test pass bits, an overall `isEqual`, and the low result byte for the 7-segment BCD path. It sits between the board controls (`enable`, `mode`) and the shared AES result mux in `main`.

## Interface
- `LATENCY`, 12: cycles from `core_start` to a stable `result`; legal range 1..255.
- `HOLD_CYCLES`, 50000000: display dwell per test; used only with `AES_SELFTEST_HOLD_EN`; legal range ≥1.

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  level; a rising edge starts a run, and a low level aborts a run or re-arms the block.
- `mode`  in  2  `00` AES-128, `01` AES-192, `10` AES-256, `11` all six tests; sampled only at start.
- `result`  in  128  output of the datapath selected by `sel_test`.
- `sel_test`  out  3  test index 0..5; `{key[1:0], dec}`, where key 0=128, 1=192, 2=256 and `dec` 1=decipher.
- `core_start`  out  1  one-cycle pulse per test.
- `busy`  out  1  high from START through the last CHECK/HOLD.
- `done`  out  1  high in DONE.
- `isEqual`  out  1  AND of the pass bits of the tests executed in the run; valid while `done` is high.
- `pass_mask`  out  6  bit i is set when test i matched.
- `disp_byte`  out  8  `result[7:0]` latched in CHECK; feeds BinarytoBCD.

## Operation
- Expected ROM contents:
  - even indices (cipher): `69c4e0d86a7b0430d8cdb78070b4c55a`, `dda97ca4864cdfe06eaf70a0ec0d7191`, `8ea2b7ca516745bfeafc49904b496089`.
  - odd indices (decipher): `00112233445566778899aabbccddeeff`.
- Run list:
  - `mode` 00/01/10: two tests, {2m, 2m+1}.
  - `mode` 11: tests 0..5 in order.
- FSM states: IDLE, START, WAIT, CHECK, HOLD, DONE.
  - IDLE → START when `enable`=1 and the registered `enable`=0 (rising edge). On this transition: latch `mode`, clear `pass_mask`, set `sel_test` to the first index.
  - START → WAIT. `core_start`=1 for this cycle; the wait counter loads `LATENCY-1`.
  - WAIT → CHECK when the counter reaches 0; otherwise the counter decrements.
  - CHECK: set `pass_mask[sel_test]` = (`result` == ROM[`sel_test`]) and latch `disp_byte`.
    - If `AES_SELFTEST_HOLD_EN` is defined, go to HOLD.
    - Otherwise go to START for the next index, or to DONE after the last index.
  - HOLD: count `HOLD_CYCLES`, then go to START for the next index, or to DONE after the last index.
  - DONE: hold all outputs; go to IDLE when `enable`=0.
- Abort: `enable`=0 in START/WAIT/CHECK/HOLD → IDLE on the next cycle.
  - `busy`=0, `done`=0.
  - `pass_mask` keeps its partial value.
  - `isEqual`=0.
- `isEqual` = &(`pass_mask` | ~`run_set_mask`), registered on entry to DONE and cleared when leaving DONE or on abort.
- A `mode` change during a run is ignored.
- `sel_test` is stable from START through CHECK/HOLD of each test.
- `enable` held high after DONE does not restart; a new rising edge is required.

## Timing
- Reset values: state IDLE, `sel_test`=0, `core_start`=0, `busy`=0, `done`=0, `isEqual`=0, `pass_mask`=0, `disp_byte`=0. `reset` overrides all other events, including mid-run.
- If `enable` rises at edge E, START is the cycle after E, with `core_start` high there (cycle T).
- CHECK occurs in cycle T+LATENCY and compares `result` at that clock edge.
- Without HOLD: test n+1 START = CHECK of test n + 1 cycle. A 2-test run asserts `done` at T+2·(LATENCY+1).
- With HOLD: HOLD occupies `HOLD_CYCLES` cycles between CHECK and the next START (or DONE).
- `pass_mask` and `disp_byte` update on the edge ending CHECK.
- Counter widths: 8 bits for WAIT; ceil(log2(`HOLD_CYCLES`+1)) bits for HOLD.

## Configuration
- `AES_SELFTEST_HOLD_EN`:
  - Defined: HOLD state and counter are present, so each test's `disp_byte` is visible for `HOLD_CYCLES`.
  - Undefined: no HOLD state or counter; CHECK goes straight to the next START or DONE, and `HOLD_CYCLES` is unused.

## Test plan
- Macro undefined, `LATENCY`=3, `mode`=00, enable 0→1, `result` model returns the correct vector 3 cycles after `core_start` → `core_start` pulses at T and T+4; `done` at T+8; `pass_mask`=000011; `isEqual`=1; `disp_byte`=ff.
- `mode`=11 with test 3 returning a corrupted value → `sel_test` sequence 0..5; `pass_mask`=110111; `isEqual`=0; `done` after 6·(LATENCY+1) cycles.
- `mode`=10 with `mode` switched to 00 mid-run → tests 4 and 5 still run; `pass_mask`=110000.
- Enable dropped during WAIT of test 1 (`mode` 11) → IDLE next cycle; `busy`=0; `pass_mask`=000001; `isEqual`=0. A new rising edge restarts at test 0 with `pass_mask` cleared.
- `reset` asserted in CHECK → all outputs at reset values on the next cycle; `enable` held high afterwards does not start a run.
- Macro defined, `HOLD_CYCLES`=5, `mode`=01 → the gap between the two `core_start` pulses is LATENCY+6 cycles; `disp_byte` shows 91, then ff.
